// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern constants and reader FSM state type
// Contents: SEG_0..SEG_F active-low gfedcba patterns, SEG_BLANK, state_t.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        COMMIT  = 3'd4
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational seven-segment pattern to hex nibble decoder
// Ports: pattern (7, active-low gfedcba) in; nibble (4) out; err out, set for patterns outside the hex table.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - samples a multiplexed active-low 7-segment bus and assembles hex frames
// Ports: clk, rst (sync, active-high); seg_in (7), an_in (NDIG) asynchronous display bus in;
//        value (4*NDIG), digit_err (NDIG), frame_valid, stale, busy out.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1000000
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     an_in,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     digit_err,
    output logic                frame_valid,
    output logic                stale,
    output logic                busy
);

    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(STABLE_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [6:0]        seg_s1, s_seg;
    logic [NDIG-1:0]   an_s1, s_an;

    logic              sel_valid;
    logic [IW-1:0]     s_idx;
    logic [3:0]        zcount;

    state_t            state, state_n;
    logic [IW-1:0]     idx_r;
    logic [6:0]        seg_r;
    logic [CW-1:0]     cnt;
    logic [NDIG-1:0]   seen;
    logic [NDIG-1:0]   idx_mask;
    logic [4*NDIG-1:0] shadow_val;
    logic [NDIG-1:0]   shadow_err;
    logic [TW-1:0]     tcnt;
    logic              same;
    logic [3:0]        dec_nib;
    logic              dec_err;

    // Two-flop synchronizers; all-ones is a blank display with no digit enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1 <= SEG_BLANK;
            s_seg  <= SEG_BLANK;
            an_s1  <= '1;
            s_an   <= '1;
        end else begin
            seg_s1 <= seg_in;
            s_seg  <= seg_s1;
            an_s1  <= an_in;
            s_an   <= an_s1;
        end
    end

    // A select is only usable when exactly one anode is low; ghosting (several low) is rejected.
    always_comb begin
        zcount = 4'd0;
        s_idx  = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!s_an[i]) begin
                zcount = zcount + 4'd1;
                s_idx  = IW'(i);
            end
        end
        sel_valid = (zcount == 4'd1);
    end

    always_comb begin
        idx_mask        = '0;
        idx_mask[idx_r] = 1'b1;
        same            = sel_valid && (s_idx == idx_r) && (s_seg == seg_r);
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_r),
        .nibble  (dec_nib),
        .err     (dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (sel_valid) state_n = SETTLE;
            SETTLE: begin
                if (!same)                           state_n = IDLE;
                else if (cnt == CW'(STABLE_CYC - 1)) state_n = CAPTURE;
            end
            CAPTURE: state_n = ((seen | idx_mask) == '1) ? COMMIT : HOLD;
            HOLD:    if (!sel_valid || (s_idx != idx_r)) state_n = IDLE;
            COMMIT:  state_n = HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= '0;
            seg_r       <= SEG_BLANK;
            cnt         <= '0;
            seen        <= '0;
            shadow_val  <= '0;
            shadow_err  <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            tcnt        <= '0;
            stale       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        idx_r <= s_idx;
                        seg_r <= s_seg;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (same && (cnt != CW'(STABLE_CYC - 1))) cnt <= cnt + 1'b1;
                end
                CAPTURE: begin
                    // Last capture of a digit wins until the frame commits.
                    shadow_val[int'(idx_r)*4 +: 4] <= dec_nib;
                    shadow_err[idx_r]              <= dec_err;
                    seen                           <= seen | idx_mask;
                end
                COMMIT: begin
                    value       <= shadow_val;
                    digit_err   <= shadow_err;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end
                default: ;
            endcase

            if (state == COMMIT) begin
                tcnt  <= '0;
                stale <= 1'b0;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                stale <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - directed self-checking bench for seg7_reader
module tb_seg7_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int          fv_count = 0;
    logic [15:0] fv_value = '0;
    logic [3:0]  fv_err   = '0;
    logic        fv_stale = 1'b0;
    int          base;

    seg7_reader #(
        .NDIG        (4),
        .STABLE_CYC  (16),
        .TIMEOUT_CYC (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .value       (value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .stale       (stale),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            fv_count <= fv_count + 1;
            fv_value <= value;
            fv_err   <= digit_err;
            fv_stale <= stale;
        end
    end

    function automatic logic [6:0] fwd(input logic [3:0] n);
        case (n)
            4'h0: fwd = 7'h40;  4'h1: fwd = 7'h79;  4'h2: fwd = 7'h24;  4'h3: fwd = 7'h30;
            4'h4: fwd = 7'h19;  4'h5: fwd = 7'h12;  4'h6: fwd = 7'h02;  4'h7: fwd = 7'h78;
            4'h8: fwd = 7'h00;  4'h9: fwd = 7'h10;  4'hA: fwd = 7'h08;  4'hB: fwd = 7'h03;
            4'hC: fwd = 7'h46;  4'hD: fwd = 7'h21;  4'hE: fwd = 7'h06;  default: fwd = 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        logic [3:0] a;
        a      = 4'b1111;
        a[d]   = 1'b0;
        an_in  = a;
        seg_in = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        an_in  = 4'b1111;
        seg_in = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3);
        show(0, fwd(d0), 200);
        show(1, fwd(d1), 200);
        show(2, fwd(d2), 200);
        show(3, fwd(d3), 200);
    endtask

    initial begin
        rst    = 1'b1;
        an_in  = 4'b1111;
        seg_in = 7'h7F;
        repeat (4) @(negedge clk);
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_digit_err", 32'(digit_err), 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);
        chk("reset_stale", 32'(stale), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Timeout: no frame for 500 cycles after reset raises stale.
        repeat (480) @(negedge clk);
        chk("stale_before_timeout", 32'(stale), 32'h0);
        repeat (40) @(negedge clk);
        chk("stale_after_timeout", 32'(stale), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("no_frame_while_blank", 32'(fv_count), 32'h0);

        // Loop-back of digits {3,7,A,F}; stale must already be clear on the frame_valid cycle.
        show(0, fwd(4'h3), 100);
        chk("busy_while_held", 32'(busy), 32'h1);
        show(0, fwd(4'h3), 100);
        show(1, fwd(4'h7), 200);
        show(2, fwd(4'hA), 200);
        show(3, fwd(4'hF), 200);
        chk("loop_frame_count", 32'(fv_count), 32'h1);
        chk("loop_value", 32'(value), 32'hFA73);
        chk("loop_digit_err", 32'(digit_err), 32'h0);
        chk("stale_at_frame_valid", 32'(fv_stale), 32'h0);
        scan(4'h3, 4'h7, 4'hA, 4'hF);
        chk("loop_second_frame_count", 32'(fv_count), 32'h2);
        chk("loop_second_value", 32'(fv_value), 32'hFA73);
        blank(10);

        // Glitch: a short-lived 3 on digit 1 must be ignored in favour of the settled 2.
        base = fv_count;
        show(0, fwd(4'h0), 200);
        show(1, 7'h30, 10);
        show(1, 7'h24, 50);
        show(2, fwd(4'h5), 200);
        show(3, fwd(4'h8), 200);
        chk("glitch_frame_count", 32'(fv_count - base), 32'h1);
        chk("glitch_value", 32'(value), 32'h8520);
        chk("glitch_digit_err", 32'(digit_err), 32'h0);
        blank(10);

        // Invalid pattern on digit 2 decodes to 0 and flags the error bit.
        base = fv_count;
        show(0, fwd(4'h1), 200);
        show(1, fwd(4'h2), 200);
        show(2, 7'h7F, 200);
        show(3, fwd(4'h4), 200);
        chk("invalid_frame_count", 32'(fv_count - base), 32'h1);
        chk("invalid_value", 32'(value), 32'h4021);
        chk("invalid_digit_err", 32'(digit_err), 32'h4);
        blank(10);

        // Ghosting: two anodes low captures nothing and leaves seen intact.
        base = fv_count;
        show(0, fwd(4'h6), 200);
        an_in  = 4'b1100;
        seg_in = fwd(4'h1);
        repeat (100) @(negedge clk);
        chk("ghost_busy", 32'(busy), 32'h0);
        chk("ghost_no_frame", 32'(fv_count - base), 32'h0);
        show(1, fwd(4'h9), 200);
        show(2, fwd(4'hB), 200);
        show(3, fwd(4'hC), 200);
        chk("ghost_frame_count", 32'(fv_count - base), 32'h1);
        chk("ghost_value", 32'(value), 32'hCB96);
        blank(10);

        // Reset mid-frame discards the partial capture of digits 0 and 1.
        show(0, fwd(4'h1), 200);
        show(1, fwd(4'h2), 200);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midreset_value", 32'(value), 32'h0);
        chk("midreset_busy", 32'(busy), 32'h0);
        base = fv_count;
        show(2, fwd(4'h5), 200);
        show(3, fwd(4'h5), 200);
        chk("midreset_no_early_frame", 32'(fv_count - base), 32'h0);
        show(0, fwd(4'h5), 200);
        show(1, fwd(4'h5), 200);
        chk("midreset_frame_count", 32'(fv_count - base), 32'h1);
        chk("midreset_value_5555", 32'(value), 32'h5555);
        chk("midreset_digit_err", 32'(digit_err), 32'h0);
        blank(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive-side counterpart of the 4-bit-to-7-segment decoder.
- Samples a multiplexed, active-low seven-segment display bus: segment lines plus per-digit anode enables.
- Waits for each digit's pattern to be stable, converts it back to its 4-bit hex value, and assembles a complete multi-digit frame.
- Used for display loop-back self-test, and for reading displays driven by external boards into the lab datapath.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
STABLE_CYC, 16, consecutive identical samples required before a digit is accepted (>=2)
TIMEOUT_CYC, 1000000, cycles without a completed frame before stale asserts

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
seg_in  input  7  segment lines {g,f,e,d,c,b,a}, active-low, asynchronous to clk
an_in  input  NDIG  digit enables, active-low, asynchronous to clk
value  output  4*NDIG  captured frame; digit i in value[4i+3:4i]
digit_err  output  NDIG  bit i set if digit i's pattern is not in the hex table
frame_valid  output  1  one-cycle pulse when value and digit_err update
stale  output  1  high while no frame has completed within TIMEOUT_CYC
busy  output  1  high when the FSM is not in IDLE

Behaviour:
- Reset: value=0, digit_err=0, frame_valid=0, stale=0, busy=0. Clear the seen mask, stability counter and timeout counter. Synchronizers load all-ones (display blank, no digit enabled).
- Input sync: seg_in and an_in each pass through a 2-FF synchronizer. All logic below uses the synchronized values (s_seg, s_an).
- Digit select: valid only when exactly one bit of s_an is 0; that bit gives the current index idx. All-ones, or more than one low bit, counts as no digit.
- Pattern table (active-low, gfedcba):
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h
  - 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh
  - Any other pattern decodes to nibble 0 with err=1.
- FSM states:
  - IDLE: waiting for a single-digit select. On a valid select, latch idx and s_seg, clear cnt, go to SETTLE.
  - SETTLE: each cycle with the same idx and the same s_seg, cnt increments. If idx changes, s_seg changes, or select becomes invalid, return to IDLE; this costs one cycle and IDLE re-evaluates. When cnt reaches STABLE_CYC-1, go to CAPTURE.
  - CAPTURE (one cycle): write the decoded nibble into the shadow register at idx, write the shadow error bit, set seen[idx]. If seen is then all-ones, go to COMMIT; otherwise go to HOLD.
  - HOLD: stay while the same idx remains selected; re-captures of the same digit are ignored. Go to IDLE when idx changes or select becomes invalid.
  - COMMIT (one cycle): copy the shadow registers to value and digit_err, pulse frame_valid, clear seen and the timeout counter, clear stale. Go to HOLD.
- Latency: a digit held stable from cycle t, as seen at the synchronizer output, is captured at t+STABLE_CYC+1. frame_valid follows one cycle after the last digit's capture.
- Recapture before frame: if a digit is captured again before the frame completes, the shadow value is overwritten (last capture wins). The seen bit stays set.
- Outputs hold between frames. value does not change except at COMMIT.
- Timeout: the counter increments every cycle it is not in COMMIT and saturates. When it reaches TIMEOUT_CYC-1, stale=1 until the next COMMIT. stale does not clear seen or the shadow registers.
- Reset mid-operation: any state returns to IDLE the cycle after rst is sampled high. The partial frame is discarded.
- busy = (state != IDLE).

Decomposition:
- Package seg7_pkg holds:
  - the 16 pattern constants (SEG_0..SEG_F);
  - the blank constant (7Fh);
  - the FSM state enum {IDLE, SETTLE, CAPTURE, HOLD, COMMIT}.
- Sub-module seg7_pattern_decode: purely combinational, 7-bit pattern in, 4-bit nibble and err out. It is the exact inverse of the team's forward decoder table.
- Synchronizers are inline.

Test Plan:
- Loop-back: drive the forward decoder's outputs for digits {3,7,A,F}, scanning NDIG=4 with 200 cycles per digit and STABLE_CYC=16. Expect frame_valid once per scan, value=F_A_7_3h (digit 3 in the top nibble), digit_err=0.
- Glitch rejection: on digit 1, show pattern 30h for 10 cycles, then switch to 24h held for 50 cycles. Expect digit 1 captured as 2, never 3.
- Invalid pattern: digit 2 shows 7Fh (blank) and the other digits are valid. Expect digit_err=0100b and value[11:8]=0, with frame_valid still pulsed.
- Ghosting: assert an_in=1100b (two digits low) for 100 cycles. Expect no capture, FSM returns to IDLE, seen unchanged.
- Timeout: with TIMEOUT_CYC=500, hold an_in=all-ones. Expect stale=1 at cycle 500 after reset; stale clears on the cycle of the next frame_valid.
- Reset mid-frame: capture digits 0 and 1, pulse rst, then scan a full frame of 5s. Expect exactly one frame_valid with value=5555h; the stale partial frame does not appear.
